// File: rtl/regfile_pkg.sv
// Purpose: shared register-file constants and types for the MIPS writeback path.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int ZERO_REG   = 0;

  // One bit per architectural register.
  typedef logic [REG_COUNT-1:0] reg_mask_t;

  // Set bit r of a register mask. Bit ZERO_REG is never set, because $zero is never written.
  function automatic reg_mask_t reg_bit(input logic [REG_ADDR_W-1:0] r);
    reg_mask_t m;
    m = '0;
    if (r != REG_ADDR_W'(ZERO_REG)) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin arbiter; one-hot grant, search starts after last_grant.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller owns the pointer and the eligibility vector.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int idx;

  // Walk last_grant+1 .. last_grant+N (mod N) and take the first requester that is set.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register-file write port between NUM_REQ writeback sources.
// Latency: accept at edge k, earliest reg_write after edge k+1, file written at edge k+2.
// Backpressure: req_ready[i] = buffer empty or being drained this cycle (refill in same cycle).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         write_register,
  output logic [DATA_W-1:0]         write_data,
  output logic [REG_COUNT-1:0]      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Per-requester one-entry buffers.
  logic [NUM_REQ-1:0] full;
  logic [ADDR_W-1:0]  ent_addr [NUM_REQ];
  logic [DATA_W-1:0]  ent_data [NUM_REQ];
  logic [NUM_REQ-1:0] load;

  // Arbitration state and result.
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (full),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  // A buffer being drained this cycle can take a new write at the same edge.
  assign req_ready = ~full | grant;

  // Accepted writes to $zero are consumed but never stored.
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      load[i] = req_valid[i] & req_ready[i] &
                (req_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG));
    end
  end

  // Buffer update: a load wins over the clear from a same-cycle grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load[i]) begin
          full[i]     <= 1'b1;
          ent_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
          ent_data[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Write stage: one registered register-file write per grant; address/data hold when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      last_grant     <= IDX_W'(NUM_REQ - 1);
    end else if (grant_vld) begin
      reg_write      <= 1'b1;
      write_register <= ent_addr[grant_idx];
      write_data     <= ent_data[grant_idx];
      last_grant     <= grant_idx;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Busy mask: destinations sitting in a buffer or in the write stage; $zero never busy.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (full[i]) busy = busy | reg_bit(REG_ADDR_W'(ent_addr[i]));
    end
    if (reg_write) busy = busy | reg_bit(REG_ADDR_W'(write_register));
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: directed self-checking bench for regfile_write_arbiter.
// Latency: checks registered outputs 1ns after each rising edge.
// Backpressure: checks req_ready against hand-derived buffer state.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;
  logic seen;
  logic any_write;

  regfile_write_arbiter #(
    .NUM_REQ (3),
    .DATA_W  (32),
    .ADDR_W  (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]        = v;
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    #1;
    // Reset values
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_wr_reg", 32'(write_register), 32'd0);
    chk("rst_wr_data", write_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd7);
    do_reset();

    // Single write from requester 0
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("t1_ready0", 32'(req_ready[0]), 32'd1);
    tick();
    req_valid = '0;
    chk("t1_busy_buf", busy, 32'h0000_0020);
    chk("t1_rw_early", 32'(reg_write), 32'd0);
    tick();
    chk("t1_rw", 32'(reg_write), 32'd1);
    chk("t1_wr_reg", 32'(write_register), 32'd5);
    chk("t1_wr_data", write_data, 32'hDEADBEEF);
    chk("t1_busy_stage", busy, 32'h0000_0020);
    tick();
    chk("t1_rw_done", 32'(reg_write), 32'd0);
    chk("t1_busy_done", busy, 32'd0);

    // Three requesters at once, held valid so grantees refill in the same cycle
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    tick();
    chk("t2_busy", busy, 32'h0000_000E);
    chk("t2_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t2_rw_%0d", k), 32'(reg_write), 32'd1);
      chk($sformatf("t2_reg_%0d", k), 32'(write_register), 32'((k % 3) + 1));
      chk($sformatf("t2_data_%0d", k), write_data, 32'(((k % 3) + 1) * 17));
      if (k == 2) req_valid = '0;
    end
    tick();
    chk("t2_idle", 32'(reg_write), 32'd0);
    chk("t2_busy_idle", busy, 32'd0);

    // Requester 1 holds its offer while 0 and 2 stream
    do_reset();
    set_req(0, 1'b1, 5'd8, 32'h80);
    set_req(1, 1'b0, 5'd9, 32'h90);
    set_req(2, 1'b1, 5'd10, 32'hA0);
    tick();
    tick();
    tick();
    req_valid[1] = 1'b1;
    tick();
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!seen) begin
        tick();
        if (reg_write && write_register == 5'd9) seen = 1'b1;
      end
    end
    chk("t3_fair_r1", 32'(seen), 32'd1);
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    chk("t3_drain_rw", 32'(reg_write), 32'd0);
    chk("t3_drain_busy", busy, 32'd0);

    // Write to $zero is accepted but discarded
    set_req(2, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("t4_ready2", 32'(req_ready[2]), 32'd1);
    tick();
    req_valid = '0;
    #1;
    chk("t4_busy", busy, 32'd0);
    chk("t4_ready_after", 32'(req_ready), 32'd7);
    tick();
    chk("t4_no_write", 32'(reg_write), 32'd0);
    tick();
    chk("t4_no_write2", 32'(reg_write), 32'd0);

    // Same destination from two requesters: later-granted value is final
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'hA);
    tick();
    chk("t5_busy_a", busy, 32'h0000_0080);
    req_valid = '0;
    set_req(1, 1'b1, 5'd7, 32'hB);
    tick();
    req_valid = '0;
    chk("t5_rw_a", 32'(reg_write), 32'd1);
    chk("t5_data_a", write_data, 32'hA);
    chk("t5_busy_both", busy, 32'h0000_0080);
    tick();
    chk("t5_rw_b", 32'(reg_write), 32'd1);
    chk("t5_reg_b", 32'(write_register), 32'd7);
    chk("t5_data_b", write_data, 32'hB);
    chk("t5_busy_b", busy, 32'h0000_0080);
    tick();
    chk("t5_rw_idle", 32'(reg_write), 32'd0);
    chk("t5_hold_data", write_data, 32'hB);
    chk("t5_busy_idle", busy, 32'd0);

    // Reset mid-operation
    do_reset();
    set_req(0, 1'b1, 5'd12, 32'hC);
    set_req(1, 1'b1, 5'd13, 32'hD);
    set_req(2, 1'b1, 5'd14, 32'hE);
    tick();
    req_valid = '0;
    tick();
    chk("t6_rw_pre", 32'(reg_write), 32'd1);
    chk("t6_busy_pre", busy, 32'h0000_7000);
    reset = 1'b1;
    #1;
    chk("t6_rst_rw", 32'(reg_write), 32'd0);
    chk("t6_rst_reg", 32'(write_register), 32'd0);
    chk("t6_rst_data", write_data, 32'd0);
    chk("t6_rst_busy", busy, 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd7);
    tick();
    reset = 1'b0;
    any_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (reg_write) any_write = 1'b1;
    end
    chk("t6_no_write_after", 32'(any_write), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32 x 32-bit MIPS register file between NUM_REQ writeback sources (ALU, load unit, multi-cycle mult/div, ...). Each source hands over a (register, data) pair through a valid/ready handshake into a private one-entry buffer. A round-robin arbiter drains the buffers into a registered write stage that drives the register file's reg_write / write_register / write_data inputs. A 32-bit busy mask tells the hazard logic which destinations still have writes in flight.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NUM_REQ  requester i offers a write
- req_ready  out  NUM_REQ  requester i's offer is accepted this cycle
- req_addr  in  NUM_REQ*ADDR_W  destination register, slice i
- req_data  in  NUM_REQ*DATA_W  write data, slice i
- reg_write  out  1  write enable to register file
- write_register  out  ADDR_W  register file write address
- write_data  out  DATA_W  register file write data
- busy  out  32  bit r = a write to register r is buffered or staged

## Operation
- Per requester: one entry (full flag, addr, data). Acceptance = req_valid[i] & req_ready[i].
- req_ready[i] = ~full[i] | grant[i]. A granted entry may be refilled in the same cycle.
- Address 0 writes: accepted (ready per rule above) but never loaded; the entry stays as it was. $zero is never written.
- Arbitration (combinational): eligible = full. Search starts at last_grant+1 and wraps modulo NUM_REQ. At most one grant per cycle.
- On grant[i] at an edge: the write stage loads reg_write=1, write_register=addr[i], write_data=data[i]. last_grant <= i. full[i] clears unless it is refilled in the same cycle.
- No grant: reg_write <= 0. write_register and write_data hold their values.
- Same destination in two buffers: the writes retire in grant order. The later-granted value is final. Callers needing program order must serialise on busy.
- busy[r] = OR over i of (full[i] & addr[i]==r), OR (reg_write & write_register==r). busy[0] is always 0.

## Timing
- Reset values: full=0, last_grant=NUM_REQ-1 (requester 0 has priority first), reg_write=0, write_register=0, write_data=0, busy=0, req_ready=all ones.
- Latency: accept at edge k -> earliest grant in cycle k..k+1 -> reg_write high after edge k+1 -> register file written at edge k+2.
- Throughput: one write per cycle overall. One write per cycle per requester when it is uncontended.
- Fairness: a full entry is granted within NUM_REQ cycles.
- Reset asserted mid-operation: buffered writes are discarded, reg_write drops immediately, and no partial write is issued.
- The write stage drives the register file for exactly one cycle per grant. Back-to-back grants give reg_write high on consecutive cycles.

## Structure
- Shared package (regfile_pkg): REG_COUNT=32, REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=0.
- Sub-module rr_arbiter (NUM_REQ request vector + last_grant in, one-hot grant out). It is reusable by other shared MIPS resources.
- The top level holds the per-requester buffers, the write stage and the busy decode.

## Test plan
- After reset, requester 0 offers (addr 5, 0xDEADBEEF) -> req_ready[0]=1, reg_write=1 with write_register=5 after the next edge, busy[5]=1 until that write retires.
- All three requesters offer in the same cycle (addr 1, 2, 3) -> reg_write is high for 3 consecutive cycles with addresses 1, 2, 3. A repeat round grants starting from requester 0 again only after requesters 1 and 2 have each been served.
- Requester 1 holds its offer continuously while requesters 0 and 2 stream offers -> requester 1 is granted within 3 cycles of its buffer filling.
- Requester 2 offers addr 0 with data 0x1234 -> req_ready[2]=1, full[2] stays 0, reg_write is never asserted, busy stays 0.
- Requester 0 offers addr 7 / 0xA, then requester 1 offers addr 7 / 0xB one cycle later -> busy[7] stays high until the second write retires, and the final write_data for register 7 is 0xB.
- Reset is asserted while two entries are full and reg_write=1 -> all outputs return to reset values immediately, and no write issues after reset is released.
